// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer definitions: tag/data widths, invalid tag and the entry record.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH      = 8;
  localparam int INST_TAG_WIDTH = $clog2(ROB_DEPTH) + 1;
  localparam int COMMON_WIDTH   = 32;
  localparam int REG_NUM        = 32;
  localparam int REG_W          = $clog2(REG_NUM);

  localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic                    valid;
    logic                    ready;
    logic                    rd_en;
    logic [REG_W-1:0]        rd;
    logic [COMMON_WIDTH-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_ptr.sv
// Modulo-DEPTH pointer with increment and clear; clear wins over increment.
module rob_ptr #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // DEPTH is a power of two, so natural overflow is the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) ptr <= '0;
    else if (inc)        ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags, captures CDB results, retires one entry
// per cycle in program order onto a registered write-back bus.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  localparam int TAG_W  = $clog2(DEPTH) + 1,
  localparam int DATA_W = COMMON_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic              alloc_rd_en,
  input  logic [4:0]        alloc_rd,
  output logic              rob_full,
  output logic [TAG_W-1:0]  rd_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              tag_clear,
  output logic              rob_empty
);

  localparam int PTR_W = TAG_W - 1;
  localparam logic [TAG_W-1:0] TAG_INV = '1;

  rob_entry_t       entries [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [TAG_W-1:0] count;
  logic             do_alloc, do_retire, cdb_hit;
  logic [PTR_W-1:0] cdb_idx;

  rob_ptr #(.DEPTH(DEPTH)) u_head (
    .clk(clk), .rst_n(rst_n), .clear(flush), .inc(do_retire), .ptr(head)
  );
  rob_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk(clk), .rst_n(rst_n), .clear(flush), .inc(do_alloc), .ptr(tail)
  );

  assign rob_full  = (count == TAG_W'(DEPTH));
  assign rob_empty = (count == '0);
  assign rd_tag    = {1'b0, tail};

  // Tags >= DEPTH (including TAG_INV) never address an entry.
  assign cdb_idx   = cdb_tag[PTR_W-1:0];
  assign cdb_hit   = cdb_valid && (cdb_tag < TAG_W'(DEPTH)) && entries[cdb_idx].valid;
  assign do_alloc  = alloc_valid && !rob_full;
  assign do_retire = entries[head].valid && entries[head].ready;

  // NOTE: only the valid/ready flags are reset; rd and data are qualified by valid,
  // so leaving the payload unreset keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].ready <= 1'b0;
      end
    end else begin
      if (cdb_hit) begin
        entries[cdb_idx].data  <= cdb_data;
        entries[cdb_idx].ready <= 1'b1;
      end
      if (do_retire) entries[head].valid <= 1'b0;
      // Written last so an allocation overrides a CDB write to the same slot.
      if (do_alloc) begin
        entries[tail].valid <= 1'b1;
        entries[tail].ready <= 1'b0;
        entries[tail].rd_en <= alloc_rd_en;
        entries[tail].rd    <= alloc_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
    end else begin
      case ({do_alloc, do_retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_tag    <= TAG_INV;
      wb_rd     <= '0;
      wb_data   <= '0;
      tag_clear <= 1'b0;
    end else if (flush) begin
      wb_tag    <= TAG_INV;
      tag_clear <= 1'b1;
    end else begin
      tag_clear <= 1'b0;
      if (do_retire) begin
        wb_tag  <= {1'b0, head};
        wb_rd   <= entries[head].rd_en ? entries[head].rd : 5'd0;
        wb_data <= entries[head].data;
      end else begin
        wb_tag  <= TAG_INV;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus queues expected write-backs in program
// order; an independent monitor compares every non-invalid wb_tag against the queue.
module tb_reorder_buffer;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam logic [TAG_W-1:0] TAG_INV = 4'hF;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              alloc_valid;
  logic              alloc_rd_en;
  logic [4:0]        alloc_rd;
  logic              rob_full;
  logic [TAG_W-1:0]  rd_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  wb_tag;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              tag_clear;
  logic              rob_empty;

  int  n_checks = 0;
  int  n_fail   = 0;
  wb_t exp_q[$];

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd_en(alloc_rd_en), .alloc_rd(alloc_rd),
    .rob_full(rob_full), .rd_tag(rd_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .wb_tag(wb_tag), .wb_rd(wb_rd), .wb_data(wb_data),
    .tag_clear(tag_clear), .rob_empty(rob_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any non-invalid write-back must match the oldest expected retirement.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_tag !== TAG_INV) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_tag), 32'(TAG_INV));
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_tag",  32'(wb_tag), 32'(e.tag));
        check("wb_rd",   32'(wb_rd),  32'(e.rd));
        check("wb_data", wb_data,     e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic alloc(input logic en, input logic [4:0] rd);
    alloc_valid = 1'b1;
    alloc_rd_en = en;
    alloc_rd    = rd;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic expect_wb(input logic [TAG_W-1:0] tag, input logic [4:0] rd,
                           input logic [DATA_W-1:0] data);
    wb_t e;
    e.tag  = tag;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    alloc_valid = 1'b0; alloc_rd_en = 1'b0; alloc_rd = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;

    // 1. Reset state
    do_reset();
    @(negedge clk);
    check("rst_empty",     32'(rob_empty), 32'd1);
    check("rst_full",      32'(rob_full),  32'd0);
    check("rst_wb_tag",    32'(wb_tag),    32'(TAG_INV));
    check("rst_rd_tag",    32'(rd_tag),    32'd0);
    check("rst_tag_clear", 32'(tag_clear), 32'd0);

    // 2. Single instruction, write-back exactly two cycles after the CDB
    expect_wb(4'd0, 5'd5, 32'hDEAD);
    alloc(1'b1, 5'd5);
    check("t2_rd_tag", 32'(rd_tag), 32'd1);
    cdb(4'd0, 32'hDEAD);
    @(negedge clk);
    check("t2_no_bypass", 32'(wb_tag), 32'(TAG_INV));
    @(negedge clk);
    check("t2_wb_now", 32'(wb_tag), 32'd0);
    @(negedge clk);
    check("t2_wb_once", 32'(wb_tag), 32'(TAG_INV));
    check("t2_empty",   32'(rob_empty), 32'd1);
    wait_drain(4);

    // 3. Out-of-order completion, in-order consecutive retirement
    do_reset();
    expect_wb(4'd0, 5'd1, 32'h10);
    expect_wb(4'd1, 5'd2, 32'h11);
    expect_wb(4'd2, 5'd3, 32'h22);
    alloc(1'b1, 5'd1);
    alloc(1'b1, 5'd2);
    alloc(1'b1, 5'd3);
    cdb(4'd2, 32'h22);
    cdb(4'd1, 32'h11);
    @(negedge clk);
    check("t3_head_blocked", 32'(wb_tag), 32'(TAG_INV));
    cdb(4'd0, 32'h10);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_consecutive", 32'(wb_tag), 32'(k));
    end
    wait_drain(4);

    // 4. Fill, full blocking, wrap, ninth allocation after one retire
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc(1'b1, 5'(i + 1));
      check("t4_rd_tag", 32'(rd_tag), 32'((i + 1) % DEPTH));
    end
    check("t4_full", 32'(rob_full), 32'd1);
    alloc(1'b1, 5'd31);
    check("t4_blocked_tag",  32'(rd_tag),   32'd0);
    check("t4_blocked_full", 32'(rob_full), 32'd1);
    expect_wb(4'd0, 5'd1, 32'h100);
    cdb(4'd0, 32'h100);
    wait_drain(6);
    check("t4_not_full", 32'(rob_full), 32'd0);
    check("t4_ninth_tag", 32'(rd_tag), 32'd0);
    alloc(1'b1, 5'd9);
    check("t4_after_ninth", 32'(rd_tag), 32'd1);
    check("t4_full_again",  32'(rob_full), 32'd1);
    for (int i = 1; i < DEPTH; i++) expect_wb(4'(i), 5'(i + 1), 32'h100 + 32'(i));
    expect_wb(4'd0, 5'd9, 32'h108);
    for (int i = 1; i < DEPTH; i++) cdb(4'(i), 32'h100 + 32'(i));
    cdb(4'd0, 32'h108);
    wait_drain(12);
    @(negedge clk);
    check("t4_drained_empty", 32'(rob_empty), 32'd1);

    // 5. Flush with four entries in flight, stale CDB afterwards
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1'b1, 5'(i + 10));
    cdb(4'd3, 32'h33);
    check("t5_pre_empty", 32'(rob_empty), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_empty",     32'(rob_empty), 32'd1);
    check("t5_tag_clear", 32'(tag_clear), 32'd1);
    check("t5_rd_tag",    32'(rd_tag),    32'd0);
    tick();
    check("t5_clear_once", 32'(tag_clear), 32'd0);
    cdb(4'd2, 32'h2222);
    for (int k = 0; k < 4; k++) tick();
    check("t5_stale_empty", 32'(rob_empty), 32'd1);
    flush = 1'b1;
    tick();
    check("t5_b2b_first", 32'(tag_clear), 32'd1);
    tick();
    flush = 1'b0;
    check("t5_b2b_second", 32'(tag_clear), 32'd1);
    tick();
    check("t5_b2b_drop", 32'(tag_clear), 32'd0);

    // 6. rd_en=0 retires with wb_rd=0; TAG_INV and out-of-range tags are ignored
    do_reset();
    alloc(1'b0, 5'd7);
    cdb(TAG_INV, 32'hBAD);
    cdb(4'd8, 32'hBAD8);
    for (int k = 0; k < 3; k++) tick();
    check("t6_still_pending", 32'(rob_empty), 32'd0);
    check("t6_no_wb", 32'(wb_tag), 32'(TAG_INV));
    expect_wb(4'd0, 5'd0, 32'h77);
    cdb(4'd0, 32'h77);
    wait_drain(6);
    @(negedge clk);
    check("t6_empty", 32'(rob_empty), 32'd1);

    tick();
    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
